axis_pulse_meas: RTL and testbench



---
 rtl/axis_pulse_meas_if.sv | 12 +
 rtl/axis_pulse_meas.sv | 178 +++++++++++++++++
 tb/tb_axis_pulse_meas.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pulse_meas_if.sv
// Single-direction AXI-Stream bundle used for both the sample input and the result output.
// The upstream sample stream never looks at tready; the result stream honours it.
interface axis_pulse_meas_if #(
  parameter int W = 64
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_pulse_meas.sv
// Threshold-based pulse measurement on a 16-lane parallel sample stream.
// Three pipeline stages (compare, reduce, track) feed a one-entry result register.
module axis_pulse_meas #(
  parameter int N = 16,
  parameter int B = 16
) (
  input  logic                aclk,
  input  logic                areset,
  axis_pulse_meas_if.slave    s_axis,
  input  logic signed [B-1:0] THR_REG,
  input  logic                EN_REG,
  axis_pulse_meas_if.master   m_axis,
  output logic [15:0]         drop_cnt
);

  localparam int PW = $clog2(N + 1);

  typedef enum logic {IDLE, IN_PULSE} state_t;

  logic [31:0]        ts;
  logic               s1_valid, s1_en;
  logic [31:0]        s1_ts;
  logic [N*B-1:0]     s1_data;
  logic [N-1:0]       s1_gt, gt;
  logic [PW-1:0]      pop;
  logic signed [B-1:0] beat_peak;
  logic               s2_valid, s2_en, s2_active;
  logic [31:0]        s2_ts;
  logic [PW-1:0]      s2_pop;
  logic signed [B-1:0] s2_peak;
  state_t             state, state_next;
  logic               start_pulse, extend_pulse, emit;
  logic [31:0]        t_start;
  logic [15:0]        width;
  logic signed [B-1:0] peak;
  logic [16:0]        width_sum;
  logic [15:0]        width_sat;
  logic               out_valid, out_load;
  logic [63:0]        out_data;

  // The input side has no flow control: every beat is taken.
  assign s_axis.tready = 1'b1;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) ts <= '0;
    else        ts <= ts + 32'd1;
  end

  always_comb begin
    gt = '0;
    for (int i = 0; i < N; i++)
      gt[i] = $signed(s_axis.tdata[B*i +: B]) > THR_REG;
  end

  // EN_REG travels with the beat so enable changes line up with beat boundaries.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s1_valid <= 1'b0;
      s1_en    <= 1'b0;
      s1_ts    <= '0;
      s1_data  <= '0;
      s1_gt    <= '0;
    end else begin
      s1_valid <= s_axis.tvalid;
      s1_en    <= EN_REG;
      s1_ts    <= ts;
      s1_data  <= s_axis.tdata;
      s1_gt    <= gt;
    end
  end

  always_comb begin
    pop       = '0;
    beat_peak = {1'b1, {(B-1){1'b0}}};
    for (int i = 0; i < N; i++) begin
      if (s1_gt[i]) begin
        pop = pop + PW'(1);
        if ($signed(s1_data[B*i +: B]) > beat_peak)
          beat_peak = $signed(s1_data[B*i +: B]);
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s2_valid  <= 1'b0;
      s2_en     <= 1'b0;
      s2_active <= 1'b0;
      s2_ts     <= '0;
      s2_pop    <= '0;
      s2_peak   <= '0;
    end else begin
      s2_valid  <= s1_valid;
      s2_en     <= s1_en;
      s2_active <= s1_valid & (|s1_gt);
      s2_ts     <= s1_ts;
      s2_pop    <= pop;
      s2_peak   <= beat_peak;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_next;
  end

  // tvalid=0 beats hold the state; disable drops any open pulse.
  always_comb begin
    state_next = state;
    if (!s2_en)
      state_next = IDLE;
    else if (s2_valid) begin
      case (state)
        IDLE:     if (s2_active)  state_next = IN_PULSE;
        IN_PULSE: if (!s2_active) state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    start_pulse  = 1'b0;
    extend_pulse = 1'b0;
    emit         = 1'b0;
    if (s2_en && s2_valid) begin
      case (state)
        IDLE:     start_pulse = s2_active;
        IN_PULSE: begin
          extend_pulse = s2_active;
          emit         = !s2_active;
        end
        default: ;
      endcase
    end
  end

  assign width_sum = {1'b0, width} + {{(17-PW){1'b0}}, s2_pop};
  assign width_sat = width_sum[16] ? 16'hFFFF : width_sum[15:0];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      t_start <= '0;
      width   <= '0;
      peak    <= '0;
    end else if (start_pulse) begin
      t_start <= s2_ts;
      width   <= {{(16-PW){1'b0}}, s2_pop};
      peak    <= s2_peak;
    end else if (extend_pulse) begin
      width <= width_sat;
      if (s2_peak > peak) peak <= s2_peak;
    end
  end

  // A result lands only if the slot is free or being drained this very cycle.
  assign out_load = emit & (~out_valid | m_axis.tready);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      drop_cnt  <= '0;
    end else begin
      if (out_load) begin
        out_valid <= 1'b1;
        out_data  <= {t_start, width, peak};
      end else if (m_axis.tready) begin
        out_valid <= 1'b0;
      end
      if (emit && !out_load && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_data;

endmodule

// File: tb/tb_axis_pulse_meas.sv
// Directed and randomized checks of axis_pulse_meas against a beat-level pulse model.
module tb_axis_pulse_meas;

  localparam int N = 16;
  localparam int B = 16;

  logic               aclk = 1'b0;
  logic               areset;
  logic signed [15:0] thr_drv;
  logic               en_drv;
  logic [15:0]        drop_cnt;

  axis_pulse_meas_if #(.W(N*B)) s_if ();
  axis_pulse_meas_if #(.W(64))  m_if ();

  always #5 aclk = ~aclk;

  axis_pulse_meas #(.N(N), .B(B)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .s_axis   (s_if),
    .THR_REG  (thr_drv),
    .EN_REG   (en_drv),
    .m_axis   (m_if),
    .drop_cnt (drop_cnt)
  );

  int          test_cnt = 0;
  int          fail_cnt = 0;
  int          cur_thr;
  logic        cur_en;
  logic [31:0] tb_ts;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  bit          m_in_pulse;
  logic [31:0] m_start;
  int          m_width;
  int          m_peak;

  always @(posedge aclk or posedge areset) begin
    if (areset) tb_ts <= '0;
    else        tb_ts <= tb_ts + 32'd1;
  end

  always @(negedge aclk) begin
    if (!areset && m_if.tvalid === 1'b1 && m_if.tready === 1'b1)
      got_q.push_back(m_if.tdata);
  end

  // A pulse is a run of valid beats with any lane above threshold; gaps in tvalid are invisible.
  task automatic modelBeat(input logic v, input logic [N*B-1:0] d, input int th,
                           input logic e, input logic [31:0] t);
    int cnt;
    int pk;
    int s;
    if (!e) begin
      m_in_pulse = 1'b0;
      return;
    end
    if (!v) return;
    cnt = 0;
    pk  = -100000;
    for (int i = 0; i < N; i++) begin
      s = int'($signed(d[16*i +: 16]));
      if (s > th) begin
        cnt++;
        if (s > pk) pk = s;
      end
    end
    if (cnt > 0) begin
      if (!m_in_pulse) begin
        m_in_pulse = 1'b1;
        m_start    = t;
        m_width    = cnt;
        m_peak     = pk;
      end else begin
        m_width = m_width + cnt;
        if (pk > m_peak) m_peak = pk;
      end
    end else if (m_in_pulse) begin
      exp_q.push_back({m_start, (m_width > 65535) ? 16'hFFFF : 16'(m_width), 16'(m_peak)});
      m_in_pulse = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [N*B-1:0] d);
    @(posedge aclk);
    #1;
    s_if.tvalid = v;
    s_if.tdata  = d;
    thr_drv     = 16'(cur_thr);
    en_drv      = cur_en;
    modelBeat(v, d, cur_thr, cur_en, tb_ts);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, '0);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkResults(input string tag);
    checkOutput({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      checkOutput(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [N*B-1:0] setLane(input logic [N*B-1:0] v, input int i, input int x);
    logic [N*B-1:0] r;
    r = v;
    r[16*i +: 16] = 16'(x);
    return r;
  endfunction

  function automatic logic [N*B-1:0] fillLanes(input int x);
    logic [N*B-1:0] r;
    for (int i = 0; i < N; i++) r[16*i +: 16] = 16'(x);
    return r;
  endfunction

  initial begin
    logic [31:0]    t1, t2, t3, t4, t5, t6;
    logic [N*B-1:0] d, base;
    logic [63:0]    first;
    int             tmp;

    areset      = 1'b1;
    cur_thr     = 100;
    cur_en      = 1'b1;
    thr_drv     = 16'sd100;
    en_drv      = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b1;
    m_in_pulse  = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("reset_tvalid", 64'(m_if.tvalid), 64'd0);
    checkOutput("reset_tdata", m_if.tdata, 64'd0);
    checkOutput("reset_drop", 64'(drop_cnt), 64'd0);
    @(posedge aclk);
    #1 areset = 1'b0;
    idle(3);

    // Single pulse and output latency
    applyStimulus(1'b1, setLane(setLane('0, 3, 500), 4, 200));
    t1 = tb_ts;
    applyStimulus(1'b1, setLane('0, 0, 150));
    applyStimulus(1'b1, '0);
    applyStimulus(1'b1, '0);
    checkOutput("lat_k1_tvalid", 64'(m_if.tvalid), 64'd0);
    applyStimulus(1'b1, '0);
    checkOutput("lat_k2_tvalid", 64'(m_if.tvalid), 64'd0);
    applyStimulus(1'b1, '0);
    checkOutput("lat_k3_tvalid", 64'(m_if.tvalid), 64'd1);
    checkOutput("lat_k3_tdata", m_if.tdata, {t1, 16'd3, 16'd500});
    applyStimulus(1'b1, '0);
    checkOutput("after_xfer_tvalid", 64'(m_if.tvalid), 64'd0);
    idle(2);
    checkResults("single");

    // Threshold equality and negative samples
    cur_thr = -50;
    base = fillLanes(-50);
    applyStimulus(1'b1, setLane(base, 1, -49));
    t2 = tb_ts;
    applyStimulus(1'b1, setLane(base, 5, 0));
    applyStimulus(1'b1, base);
    idle(5);
    checkOutput("neg_result", (got_q.size() > 0) ? got_q[0] : 64'hx, {t2, 16'd2, 16'd0});
    checkResults("neg");

    // tvalid gaps neither end nor extend a pulse
    cur_thr = 100;
    applyStimulus(1'b1, setLane('0, 2, 120));
    t3 = tb_ts;
    idle(5);
    applyStimulus(1'b1, setLane(setLane('0, 0, 300), 1, 400));
    applyStimulus(1'b1, '0);
    idle(5);
    checkOutput("gap_result", (got_q.size() > 0) ? got_q[0] : 64'hx, {t3, 16'd3, 16'd400});
    checkResults("gap");

    // Backpressure: first result held, two dropped
    m_if.tready = 1'b0;
    t4 = '0;
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1'b1, setLane('0, 0, 200 + p * 10));
      if (p == 0) t4 = tb_ts;
      applyStimulus(1'b1, '0);
    end
    idle(5);
    first = {t4, 16'd1, 16'd200};
    checkOutput("bp_tvalid", 64'(m_if.tvalid), 64'd1);
    checkOutput("bp_tdata", m_if.tdata, first);
    checkOutput("bp_drop", 64'(drop_cnt), 64'd2);
    idle(3);
    checkOutput("bp_hold", m_if.tdata, first);
    m_if.tready = 1'b1;
    applyStimulus(1'b0, '0);
    checkOutput("bp_release_tvalid", 64'(m_if.tvalid), 64'd0);
    idle(2);
    if (exp_q.size() == 3) begin
      exp_q.delete(2);
      exp_q.delete(1);
    end
    checkResults("bp");

    // Enable dropped mid-pulse discards the open pulse
    applyStimulus(1'b1, setLane('0, 0, 500));
    cur_en = 1'b0;
    applyStimulus(1'b1, '0);
    applyStimulus(1'b1, setLane('0, 0, 700));
    idle(2);
    cur_en = 1'b1;
    applyStimulus(1'b1, setLane('0, 0, 300));
    t5 = tb_ts;
    applyStimulus(1'b1, '0);
    idle(5);
    checkOutput("en_result", (got_q.size() > 0) ? got_q[0] : 64'hx, {t5, 16'd1, 16'd300});
    checkResults("en");

    // Width saturation over 4097 fully active beats
    t6 = '0;
    for (int b = 0; b < 4097; b++) begin
      for (int i = 0; i < N; i++) d[16*i +: 16] = 16'($urandom_range(2000, 101));
      applyStimulus(1'b1, d);
      if (b == 0) t6 = tb_ts;
    end
    applyStimulus(1'b1, '0);
    idle(5);
    checkOutput("sat_width", (got_q.size() > 0) ? 64'(got_q[0][31:16]) : 64'hx, 64'hFFFF);
    checkOutput("sat_start", (got_q.size() > 0) ? 64'(got_q[0][63:32]) : 64'hx, 64'(t6));
    checkResults("sat");

    // Reset with a pending result and an open pulse
    m_if.tready = 1'b0;
    applyStimulus(1'b1, setLane('0, 0, 400));
    applyStimulus(1'b1, '0);
    applyStimulus(1'b1, setLane('0, 1, 900));
    applyStimulus(1'b1, setLane('0, 1, 950));
    applyStimulus(1'b1, setLane('0, 2, 990));
    checkOutput("rst_pending_tvalid", 64'(m_if.tvalid), 64'd1);
    applyStimulus(1'b1, setLane('0, 2, 990));
    #2;
    areset      = 1'b1;
    s_if.tvalid = 1'b0;
    #1;
    checkOutput("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    checkOutput("rst_tdata", m_if.tdata, 64'd0);
    checkOutput("rst_drop", 64'(drop_cnt), 64'd0);
    m_in_pulse = 1'b0;
    exp_q.delete();
    got_q.delete();
    @(posedge aclk);
    #1 areset = 1'b0;
    m_if.tready = 1'b1;
    repeat (8) applyStimulus(1'b1, '0);
    checkResults("rst");

    // Randomized beats with occasional threshold and enable changes
    for (int b = 0; b < 600; b++) begin
      logic v;
      int   kind;
      if (b % 150 == 0) begin
        tmp     = int'($urandom_range(200, 0)) - 100;
        cur_thr = tmp;
      end
      if ($urandom % 60 == 0) cur_en = ~cur_en;
      v    = ($urandom % 4) != 0;
      kind = int'($urandom % 3);
      for (int i = 0; i < N; i++) begin
        if (kind != 0 && ($urandom % 2) == 1)
          tmp = cur_thr + int'($urandom_range(500, 1));
        else
          tmp = cur_thr - int'($urandom_range(500, 0));
        d[16*i +: 16] = 16'(tmp);
      end
      applyStimulus(v, d);
    end
    cur_en = 1'b1;
    repeat (6) applyStimulus(1'b1, fillLanes(-32768));
    checkResults("rand");

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
